// File: rtl/x86_dec_pkg.sv
// Shared encodings for the byte-serial x86 operand decoder: FSM states,
// field size codes, supported opcodes and ModR/M special values.
package x86_dec_pkg;

  localparam logic [2:0] S_OPC   = 3'd0;
  localparam logic [2:0] S_MODRM = 3'd1;
  localparam logic [2:0] S_SIB   = 3'd2;
  localparam logic [2:0] S_DISP  = 3'd3;
  localparam logic [2:0] S_IMM   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_8    = 2'b01;
  localparam logic [1:0] SZ_32   = 2'b10;

  localparam logic [7:0] OP_ADD_RM_R   = 8'h01;
  localparam logic [7:0] OP_ADD_R_RM   = 8'h03;
  localparam logic [7:0] OP_OR_RM_R    = 8'h09;
  localparam logic [7:0] OP_OR_R_RM    = 8'h0B;
  localparam logic [7:0] OP_GRP1_IMM32 = 8'h81;
  localparam logic [7:0] OP_GRP1_IMM8  = 8'h83;
  localparam logic [7:0] OP_GRP2_IMM8  = 8'hC1;
  localparam logic [7:0] OP_ADD_EAX_I  = 8'h05;
  localparam logic [7:0] OP_OR_EAX_I   = 8'h0D;
  localparam logic [7:0] OP_JMP_REL32  = 8'hE9;
  localparam logic [7:0] OP_JMP_REL8   = 8'hEB;
  localparam logic [7:0] OP_NOP        = 8'h90;

  localparam logic [1:0] MOD_REG   = 2'b11;
  localparam logic [2:0] RM_SIB    = 3'b100;
  localparam logic [2:0] RM_DISP32 = 3'b101;

  typedef struct packed {
    logic       has_modrm;
    logic [1:0] imm_size;
    logic       illegal;
  } op_class_t;

  // Displacement size implied by mod; base is rm (no SIB) or the SIB base.
  function automatic logic [1:0] disp_size_for(input logic [1:0] mod,
                                               input logic [2:0] base);
    case (mod)
      2'b01:   disp_size_for = SZ_8;
      2'b10:   disp_size_for = SZ_32;
      2'b00:   disp_size_for = (base == RM_DISP32) ? SZ_32 : SZ_NONE;
      default: disp_size_for = SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/x86_operand_decoder_lut.sv
// Opcode classification: which fields follow the opcode byte.
module opcode_class_lut
  import x86_dec_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_t  op_class
);

  // Table lookup; anything not listed is flagged illegal with no fields.
  always_comb begin
    op_class = '0;
    case (opcode)
      OP_ADD_RM_R, OP_ADD_R_RM, OP_OR_RM_R, OP_OR_R_RM:
        op_class.has_modrm = 1'b1;
      OP_GRP1_IMM32: begin
        op_class.has_modrm = 1'b1;
        op_class.imm_size  = SZ_32;
      end
      OP_GRP1_IMM8, OP_GRP2_IMM8: begin
        op_class.has_modrm = 1'b1;
        op_class.imm_size  = SZ_8;
      end
      OP_ADD_EAX_I, OP_OR_EAX_I, OP_JMP_REL32:
        op_class.imm_size = SZ_32;
      OP_JMP_REL8:
        op_class.imm_size = SZ_8;
      OP_NOP: ;
      default:
        op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/x86_operand_decoder.sv
// Byte-serial x86 instruction parser: opcode -> ModR/M -> SIB -> disp -> imm,
// presenting one decoded instruction on a valid/ready output.
module x86_operand_decoder
  import x86_dec_pkg::*;
#(
  parameter bit NARROW_MSB_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        flush,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  opcode,
  output logic [7:0]  modrm,
  output logic [7:0]  sib,
  output logic        has_modrm,
  output logic        has_sib,
  output logic [31:0] disp,
  output logic [1:0]  disp_size,
  output logic [31:0] imm,
  output logic [1:0]  imm_size,
  output logic [3:0]  inst_len,
  output logic        illegal
);

  logic [2:0]  state;
  logic [1:0]  cnt;
  op_class_t   cls;
  logic        accept;
  logic        clear_inst;
  logic [1:0]  ds_modrm;
  logic [1:0]  ds_sib;
  logic [31:0] narrow_word;

  opcode_class_lut u_lut (
    .opcode   (byte_in),
    .op_class (cls)
  );

  // First non-empty field after the current one, else done.
  function automatic logic [2:0] field_next(input logic [1:0] dsz,
                                            input logic [1:0] isz);
    if (dsz != SZ_NONE)      field_next = S_DISP;
    else if (isz != SZ_NONE) field_next = S_IMM;
    else                     field_next = S_DONE;
  endfunction

  assign byte_ready  = clr & ~flush & (state != S_DONE);
  assign out_valid   = (state == S_DONE);
  assign accept      = byte_valid & byte_ready;
  assign clear_inst  = flush | (out_valid & out_ready);
  assign ds_modrm    = disp_size_for(byte_in[7:6], byte_in[2:0]);
  assign ds_sib      = disp_size_for(modrm[7:6], byte_in[2:0]);
  assign narrow_word = NARROW_MSB_ALIGN ? {byte_in, 24'h0} : {24'h0, byte_in};

  // Parser FSM and field registers; flush and the output handshake share
  // the same clear path back to S_OPC.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_OPC;  cnt <= '0;      opcode <= '0;   modrm <= '0;
      sib <= '0;       has_modrm <= '0; has_sib <= '0; disp <= '0;
      disp_size <= '0; imm <= '0;      imm_size <= '0; inst_len <= '0;
      illegal <= '0;
    end else if (clear_inst) begin
      state <= S_OPC;  cnt <= '0;      opcode <= '0;   modrm <= '0;
      sib <= '0;       has_modrm <= '0; has_sib <= '0; disp <= '0;
      disp_size <= '0; imm <= '0;      imm_size <= '0; inst_len <= '0;
      illegal <= '0;
    end else if (accept) begin
      inst_len <= inst_len + 4'd1;
      case (state)
        S_OPC: begin
          opcode    <= byte_in;
          has_modrm <= cls.has_modrm;
          imm_size  <= cls.imm_size;
          illegal   <= cls.illegal;
          cnt       <= '0;
          if (cls.illegal)        state <= S_DONE;
          else if (cls.has_modrm) state <= S_MODRM;
          else                    state <= field_next(SZ_NONE, cls.imm_size);
        end
        S_MODRM: begin
          modrm <= byte_in;
          if (byte_in[7:6] != MOD_REG && byte_in[2:0] == RM_SIB) begin
            state <= S_SIB;
          end else begin
            disp_size <= ds_modrm;
            state     <= field_next(ds_modrm, imm_size);
          end
        end
        S_SIB: begin
          sib       <= byte_in;
          has_sib   <= 1'b1;
          disp_size <= ds_sib;
          state     <= field_next(ds_sib, imm_size);
        end
        S_DISP: begin
          if (disp_size == SZ_8) disp <= narrow_word;
          else                   disp[{cnt, 3'b000} +: 8] <= byte_in;
          if (disp_size == SZ_8 || cnt == 2'd3) begin
            cnt   <= '0;
            state <= field_next(SZ_NONE, imm_size);
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_IMM: begin
          if (imm_size == SZ_8) imm <= narrow_word;
          else                  imm[{cnt, 3'b000} +: 8] <= byte_in;
          if (imm_size == SZ_8 || cnt == 2'd3) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= S_OPC;
      endcase
    end
  end

endmodule

// File: tb/tb_x86_operand_decoder.sv
// Directed bench for x86_operand_decoder with a byte-list reference model.
module tb_x86_operand_decoder;

  localparam bit NARROW = 1'b1;

  logic        clk = 1'b0;
  logic        clr, flush, byte_valid, out_ready;
  logic [7:0]  byte_in;
  logic        byte_ready, out_valid, has_modrm, has_sib, illegal;
  logic [7:0]  opcode, modrm, sib;
  logic [31:0] disp, imm;
  logic [1:0]  disp_size, imm_size;
  logic [3:0]  inst_len;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  opcode, modrm, sib;
    logic        has_modrm, has_sib, illegal;
    logic [31:0] disp, imm;
    logic [1:0]  disp_size, imm_size;
    logic [3:0]  len;
  } exp_t;

  exp_t exp_q;
  bit   exp_pending = 1'b0;

  x86_operand_decoder #(.NARROW_MSB_ALIGN(NARROW)) dut (
    .clk(clk), .clr(clr), .flush(flush), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .modrm(modrm), .sib(sib),
    .has_modrm(has_modrm), .has_sib(has_sib), .disp(disp),
    .disp_size(disp_size), .imm(imm), .imm_size(imm_size),
    .inst_len(inst_len), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] field_val(input logic [7:0] b [0:10],
                                            input int p, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(b[p + k]) << (8 * k));
    if (n == 1 && NARROW) v = v << 24;
    return v;
  endfunction

  function automatic logic [1:0] size_code(input int n);
    return (n == 1) ? 2'd1 : (n == 4) ? 2'd2 : 2'd0;
  endfunction

  // Parse a byte list directly from the instruction-format rules.
  function automatic exp_t model(input logic [7:0] b [0:10]);
    exp_t e;
    int p = 1, dn = 0, in_n = 0, base = 0;
    bit mrm = 1'b0;
    e = '{default: '0};
    e.opcode = b[0];
    case (b[0])
      8'h01, 8'h03, 8'h09, 8'h0B: mrm = 1'b1;
      8'h81: begin mrm = 1'b1; in_n = 4; end
      8'h83, 8'hC1: begin mrm = 1'b1; in_n = 1; end
      8'h05, 8'h0D, 8'hE9: in_n = 4;
      8'hEB: in_n = 1;
      8'h90: ;
      default: e.illegal = 1'b1;
    endcase
    if (mrm) begin
      e.has_modrm = 1'b1;
      e.modrm = b[1];
      p = 2;
      base = int'(b[1][2:0]);
      if (b[1][7:6] != 2'b11 && b[1][2:0] == 3'd4) begin
        e.has_sib = 1'b1;
        e.sib = b[2];
        p = 3;
        base = int'(b[2][2:0]);
      end
      case (b[1][7:6])
        2'b01:   dn = 1;
        2'b10:   dn = 4;
        2'b00:   dn = (base == 5) ? 4 : 0;
        default: dn = 0;
      endcase
    end
    e.disp = field_val(b, p, dn);
    e.disp_size = size_code(dn);
    p += dn;
    e.imm = field_val(b, p, in_n);
    e.imm_size = size_code(in_n);
    p += in_n;
    e.len = 4'(p);
    return e;
  endfunction

  // Compare DUT against the model on every cycle a decode is presented.
  always @(negedge clk) begin
    if (clr === 1'b1 && out_valid === 1'b1) begin
      if (!exp_pending) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("m_opcode",    32'(opcode),    32'(exp_q.opcode));
        check("m_modrm",     32'(modrm),     32'(exp_q.modrm));
        check("m_sib",       32'(sib),       32'(exp_q.sib));
        check("m_has_modrm", 32'(has_modrm), 32'(exp_q.has_modrm));
        check("m_has_sib",   32'(has_sib),   32'(exp_q.has_sib));
        check("m_disp",      disp,           exp_q.disp);
        check("m_disp_size", 32'(disp_size), 32'(exp_q.disp_size));
        check("m_imm",       imm,            exp_q.imm);
        check("m_imm_size",  32'(imm_size),  32'(exp_q.imm_size));
        check("m_inst_len",  32'(inst_len),  32'(exp_q.len));
        check("m_illegal",   32'(illegal),   32'(exp_q.illegal));
      end
    end
  end

  function automatic void unpack(input logic [87:0] p, input int n,
                                 output logic [7:0] b [0:10]);
    for (int i = 0; i < 11; i++) b[i] = (i < n) ? p[8 * (n - 1 - i) +: 8] : 8'h00;
  endfunction

  // Offer n bytes; optionally insert one idle cycle before byte index gap.
  task automatic feed(input logic [7:0] b [0:10], input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i == gap) begin
        byte_valid = 1'b0;
        byte_in = 8'hAA;
        @(posedge clk); #1;
        check("stall_len", 32'(inst_len), 32'(i));
      end
      byte_in = b[i];
      byte_valid = 1'b1;
      for (int w = 0; !byte_ready; w++) begin
        if (w > 20) begin
          check("accept_timeout", 32'(byte_ready), 32'd1);
          byte_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_inst(input logic [87:0] p, input int n, input int gap);
    logic [7:0] b [0:10];
    unpack(p, n, b);
    exp_q = model(b);
    check("model_len", 32'(exp_q.len), 32'(n));
    exp_pending = 1'b1;
    feed(b, n, gap);
    check("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_inst(input int hold);
    for (int h = 0; h < hold; h++) begin
      check("hold_byte_ready", 32'(byte_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_pending = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_inst_len", 32'(inst_len), 32'd0);
    check("post_byte_ready", 32'(byte_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] pb [0:10];
    clr = 1'b0; flush = 1'b0; byte_valid = 1'b0; out_ready = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_inst_len", 32'(inst_len), 32'd0);
    check("rst_disp", disp, 32'd0);
    clr = 1'b1;
    #1;
    check("rel_byte_ready", 32'(byte_ready), 32'd1);
    @(posedge clk); #1;

    run_inst(88'h039DCDAB00FF, 6, 3);
    check("v1_modrm", 32'(modrm), 32'h9D);
    check("v1_disp", disp, 32'hFF00ABCD);
    check("v1_disp_size", 32'(disp_size), 32'd2);
    check("v1_imm_size", 32'(imm_size), 32'd0);
    check("v1_len", 32'(inst_len), 32'd6);
    check("v1_illegal", 32'(illegal), 32'd0);
    finish_inst(0);

    run_inst(88'h81450878563412, 7, -1);
    check("v2_modrm", 32'(modrm), 32'h45);
    check("v2_disp", disp, 32'h08000000);
    check("v2_disp_size", 32'(disp_size), 32'd1);
    check("v2_imm", imm, 32'h12345678);
    check("v2_imm_size", 32'(imm_size), 32'd2);
    check("v2_len", 32'(inst_len), 32'd7);
    finish_inst(0);

    run_inst(88'h03042544332211, 7, -1);
    check("v3_has_sib", 32'(has_sib), 32'd1);
    check("v3_sib", 32'(sib), 32'h25);
    check("v3_disp", disp, 32'h11223344);
    check("v3_len", 32'(inst_len), 32'd7);
    finish_inst(0);

    run_inst(88'h010424, 3, -1);
    check("v4_sib", 32'(sib), 32'h24);
    check("v4_disp_size", 32'(disp_size), 32'd0);
    check("v4_len", 32'(inst_len), 32'd3);
    finish_inst(0);

    run_inst(88'h83C3F0, 3, -1);
    check("v5_imm", imm, 32'hF0000000);
    check("v5_len", 32'(inst_len), 32'd3);
    finish_inst(5);

    run_inst(88'h0F, 1, -1);
    check("v6_illegal", 32'(illegal), 32'd1);
    check("v6_len", 32'(inst_len), 32'd1);
    finish_inst(0);

    run_inst(88'h90, 1, -1);
    check("v7_illegal", 32'(illegal), 32'd0);
    check("v7_len", 32'(inst_len), 32'd1);
    check("v7_sizes", 32'({disp_size, imm_size}), 32'd0);
    finish_inst(0);

    run_inst(88'h8184254433221178563412, 11, 5);
    check("max_len", 32'(inst_len), 32'd11);
    check("max_imm", imm, 32'h12345678);
    finish_inst(1);

    run_inst(88'h0BC8, 2, -1);              finish_inst(0);
    run_inst(88'hC1E004, 3, -1);            finish_inst(0);
    run_inst(88'h090578563412, 6, -1);      finish_inst(0);
    run_inst(88'hE944332211, 5, -1);        finish_inst(0);
    run_inst(88'h0D01000000, 5, -1);        finish_inst(0);
    run_inst(88'h83442408_7F, 5, -1);       finish_inst(0);
    run_inst(88'h814C2410EFBEADDE, 8, -1);  finish_inst(0);

    // Flush mid-immediate: partial instruction dropped, presented byte refused.
    unpack(88'h81C01122, 4, pb);
    feed(pb, 4, -1);
    flush = 1'b1;
    byte_in = 8'h33;
    byte_valid = 1'b1;
    #1;
    check("flush_byte_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    byte_valid = 1'b0;
    check("flush_inst_len", 32'(inst_len), 32'd0);
    check("flush_imm", imm, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("flush_no_valid", 32'(out_valid), 32'd0);
    end
    run_inst(88'hEBFE, 2, -1);
    check("v8_imm", imm, 32'hFE000000);
    check("v8_len", 32'(inst_len), 32'd2);
    finish_inst(0);

    // Asynchronous reset mid-displacement.
    unpack(88'h039DCD, 3, pb);
    feed(pb, 3, -1);
    #2;
    clr = 1'b0;
    #1;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_opcode", 32'(opcode), 32'd0);
    check("clr_modrm", 32'(modrm), 32'd0);
    check("clr_disp", disp, 32'd0);
    check("clr_disp_size", 32'(disp_size), 32'd0);
    check("clr_inst_len", 32'(inst_len), 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    #1;
    check("clr_rel_ready", 32'(byte_ready), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      check("clr_no_valid", 32'(out_valid), 32'd0);
    end
    run_inst(88'h90, 1, -1);
    finish_inst(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
